// File: rtl/pipe.sv
`default_nettype none
// ============================================================================
// Module      : pipe
// Description : Iterative SHA-256 compression core. One round per clock over
//               working registers a..h, followed by the final feed-forward add
//               of the initial hash words. Starts automatically on reset
//               release and holds the digest until the next reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:7][31:0]    H_in,
    input  logic [0:63][31:0]   W,
    output logic                done,
    output logic [255:0]        H_out
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_FINISH = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [0:63][31:0] c_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [1:0]         r_state;
    logic [5:0]         r_t;
    logic [31:0]        r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [0:7][31:0]   r_h_init;

    logic [31:0]        w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;

    // Fixed-amount rotations are pure wiring.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    // Round function for the current round t; carries beyond 32 bits drop.
    always_comb begin
        w_sig0 = rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22);
        w_sig1 = rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25);
        w_ch   = (r_e & r_f) ^ (~r_e & r_g);
        w_maj  = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
        w_t1   = r_h + w_sig1 + w_ch + c_K[r_t] + W[r_t];
        w_t2   = w_sig0 + w_maj;
    end

    // Control FSM, working registers and registered digest output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_RUN;
            r_t      <= 6'd0;
            r_a      <= H_in[0];
            r_b      <= H_in[1];
            r_c      <= H_in[2];
            r_d      <= H_in[3];
            r_e      <= H_in[4];
            r_f      <= H_in[5];
            r_g      <= H_in[6];
            r_h      <= H_in[7];
            r_h_init <= H_in;
            done     <= 1'b0;
            H_out    <= 256'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_h <= r_g;
                    r_g <= r_f;
                    r_f <= r_e;
                    r_e <= r_d + w_t1;
                    r_d <= r_c;
                    r_c <= r_b;
                    r_b <= r_a;
                    r_a <= w_t1 + w_t2;
                    r_t <= r_t + 6'd1;
                    if (r_t == 6'd63) begin
                        r_state <= c_ST_FINISH;
                    end
                end
                c_ST_FINISH: begin
                    H_out <= {r_h_init[0] + r_a, r_h_init[1] + r_b,
                              r_h_init[2] + r_c, r_h_init[3] + r_d,
                              r_h_init[4] + r_e, r_h_init[5] + r_f,
                              r_h_init[6] + r_g, r_h_init[7] + r_h};
                    done    <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    // Digest and done are held until the next reset.
                end
                default: begin
                    r_state <= c_ST_DONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe
// Description : Self-checking bench for pipe. A reference SHA-256 model
//               predicts done/H_out every cycle; directed scenarios add
//               literal digest checks for "abc" and the empty message.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic [0:7][31:0]   H_in;
    logic [0:63][31:0]  W;
    logic               done;
    logic [255:0]       H_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [0:7][31:0] c_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] c_ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [0:63][31:0] c_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    pipe u_dut (
        .clk   (clk),
        .reset (reset),
        .H_in  (H_in),
        .W     (W),
        .done  (done),
        .H_out (H_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        rr = (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion of one 512-bit padded block.
    function automatic logic [0:63][31:0] sched(input logic [511:0] blk);
        logic [0:63][31:0] s;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) s[t] = blk[511 - 32*t -: 32];
            else s[t] = (rr(s[t-2], 17) ^ rr(s[t-2], 19) ^ (s[t-2] >> 10))
                        + s[t-7]
                        + (rr(s[t-15], 7) ^ rr(s[t-15], 18) ^ (s[t-15] >> 3))
                        + s[t-16];
        end
        return s;
    endfunction

    // Reference compression: working state kept as an array and shifted.
    function automatic logic [255:0] sha_compress(input logic [0:7][31:0] hi,
                                                  input logic [0:63][31:0] w);
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hi[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hi[i] + v[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-level model: edges since reset release, inputs captured at reset.
    int               m_cnt = 0;
    bit               m_valid = 1'b0;
    logic [0:7][31:0] m_hcap;
    logic [255:0]     m_digest = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt    <= 0;
            m_hcap   <= H_in;
            m_digest <= '0;
            m_valid  <= 1'b1;
        end else if (m_cnt < 65) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 64) m_digest <= sha_compress(m_hcap, W);
        end
    end

    // Per-cycle comparison of done and H_out against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_done", {255'd0, done}, {255'd0, (m_cnt == 65)});
            check("cyc_hout", H_out, (m_cnt == 65) ? m_digest : 256'd0);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Hold reset for n edges with the given inputs, checking reset outputs.
    task automatic do_reset(input logic [0:7][31:0] h, input logic [0:63][31:0] w,
                            input int n);
        reset = 1'b1;
        H_in  = h;
        W     = w;
        for (int i = 0; i < n; i++) begin
            edges(1);
            check("rst_done", {255'd0, done}, 256'd0);
            check("rst_hout", H_out, 256'd0);
        end
        reset = 1'b0;
    endtask

    // Bounded wait for done; an expired bound counts as a failure.
    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            edges(1);
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_timeout: done=%b after %0d edges, required 1", name, done, k);
        end
    endtask

    logic [0:63][31:0] w_abc, w_empty, w_zero;
    logic [255:0]      exp_v;

    initial begin
        w_abc   = sched({32'h61626380, 416'd0, 64'h18});
        w_empty = sched({32'h80000000, 480'd0});
        w_zero  = '0;
        reset   = 1'b1;
        H_in    = c_IV;
        W       = w_abc;

        // Pin the reference model against published digests.
        check("model_abc", sha_compress(c_IV, w_abc), c_ABC_DIGEST);
        check("model_empty", sha_compress(c_IV, w_empty), c_EMPTY_DIGEST);

        // "abc" block.
        do_reset(c_IV, w_abc, 2);
        edges(64);
        check("abc_done_e64", {255'd0, done}, 256'd0);
        edges(1);
        check("abc_done_e65", {255'd0, done}, 256'd1);
        check("abc_digest", H_out, c_ABC_DIGEST);

        // Empty message block.
        do_reset(c_IV, w_empty, 1);
        edges(65);
        check("empty_digest", H_out, c_EMPTY_DIGEST);

        // Zero state and schedule: exact latency edges.
        do_reset('0, w_zero, 2);
        edges(64);
        check("zero_done_e64", {255'd0, done}, 256'd0);
        check("zero_hout_e64", H_out, 256'd0);
        edges(1);
        check("zero_done_e65", {255'd0, done}, 256'd1);
        check("zero_digest", H_out, sha_compress('0, w_zero));

        // Abort at round 30 of an "abc" run, then restart cleanly.
        do_reset(c_IV, w_abc, 1);
        edges(30);
        do_reset(c_IV, w_abc, 3);
        edges(64);
        check("abort_done_e64", {255'd0, done}, 256'd0);
        edges(1);
        check("abort_digest", H_out, c_ABC_DIGEST);

        // Inputs changing in DONE are ignored until reset.
        H_in = '0;
        W    = w_empty;
        edges(10);
        check("hold_done", {255'd0, done}, 256'd1);
        check("hold_digest", H_out, c_ABC_DIGEST);
        do_reset('0, w_empty, 1);
        exp_v = sha_compress('0, w_empty);
        wait_done("recompute");
        check("recompute_digest", H_out, exp_v);
        edges(5);
        check("recompute_hold", H_out, exp_v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe.md
PIPE -- requirements
Module: pipe

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; only clock domain.
REQ-002 SHALL have port: reset  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: H_in  input  8x32 packed [0:7][31:0]  initial hash words; H_in[0]=H0 … H_in[7]=H7.
REQ-004 SHALL have port: W  input  64x32 packed [0:63][31:0]  pre-expanded SHA-256 message schedule; W[t] is used in round t.
REQ-005 SHALL have port: done  output  1  high when H_out holds the final result.
REQ-006 SHALL have port: H_out  output  256  compressed hash; [255:224]=H0' … [31:0]=H7'.
REQ-007 SHALL have no start/valid input; operation begins automatically when reset deasserts.

Function
REQ-008 SHALL implement one SHA-256 compression: 64 rounds per FIPS 180-4 with the 64 standard K constants held internally.
REQ-009 SHALL use an iterative datapath: one round per clock, working registers a..h, 6-bit round counter t.
REQ-010 SHALL compute each round as T1=h+Σ1(e)+Ch(e,f,g)+K[t]+W[t] and T2=Σ0(a)+Maj(a,b,c).
REQ-011 SHALL update the working registers each round as h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
REQ-012 SHALL define Σ0=ROTR2^ROTR13^ROTR22, Σ1=ROTR6^ROTR11^ROTR25, Ch=(e&f)^(~e&g), Maj=(a&b)^(a&c)^(b&c).
REQ-013 SHALL perform all additions modulo 2^32, discarding carries.
REQ-014 SHALL use a 3-state FSM: RUN (rounds), FINISH (final add), DONE (hold).
REQ-015 SHALL make reset force state RUN, t=0, a..h←H_in[0..7], and capture H_in into an internal H_init register.
REQ-016 SHALL, in RUN, perform round t on each rising edge with reset low and increment t.
REQ-017 SHALL move from RUN to FINISH on the edge that executes round 63.
REQ-018 SHALL, in FINISH, on the next edge register H_out={H_init[i]+working[i]} for i=0..7 (mod 2^32 per word), set done=1, and move to DONE.
REQ-019 SHALL give a latency of exactly 65 rising edges from the first edge with reset low to done=1.
REQ-020 SHALL, in DONE, hold H_out and done=1 and ignore input changes until reset.
REQ-021 SHALL require W to be stable from reset deassertion until done, and SHALL read H_in only while reset is high.
REQ-022 SHALL keep done=0 and H_out=0 while in RUN or FINISH.

Reset
REQ-023 SHALL, on any edge with reset=1, set done=0, H_out=0, t=0, state=RUN, and reload a..h and H_init from H_in.
REQ-024 SHALL let reset asserted mid-computation or in DONE abort and restart cleanly, with no residue from the prior run.
REQ-025 SHALL let reset held for multiple cycles keep all outputs at reset values, with the 65-edge latency counted from the first edge with reset low.

Verification
REQ-026 SHALL pass this scenario: H_in=standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), W=schedule of padded "abc" -> after 65 edges done=1, H_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-027 SHALL pass this scenario: IV, W=schedule of padded empty message -> H_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-028 SHALL pass this scenario: H_in=0, W=0, reset for 2 edges then released -> done=0 for edges 1..64 and done=1 at edge 65, with H_out matching a golden model of the FIPS round function on zero state/schedule.
REQ-029 SHALL pass this scenario: reset asserted at round 30 of the "abc" run, then released -> done stays 0 and H_out=0 during reset, and the "abc" digest appears 65 edges after release.
REQ-030 SHALL pass this scenario: after done, change H_in and W without reset -> H_out and done unchanged; then pulse reset -> done=0, H_out=0, and recomputation uses the new inputs.
REQ-031 SHALL pass this scenario: check done each cycle -> never asserted before edge 65 and never deasserted without reset.
